// File: rtl/bram32_copier_pkg.sv
// Shared types and constants for the BRAM word copier / filler.
// State encoding is exposed on dbg_state, so its numeric values stay fixed.
package bram32_copier_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = ADDR_W - 2;
  localparam int DATA_W = 32;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FILL   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [WORD_W-1:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/bram32_agen.sv
// Source/destination word pointers and remaining-word counter for one transfer.
// Pointers are word-granular, so byte addresses wrap modulo 2^16 for free.
module bram32_agen
  import bram32_copier_pkg::*;
#(
  parameter int len_width = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 adv_i,
  input  logic [WORD_W-1:0]    src_i,
  input  logic [WORD_W-1:0]    dst_i,
  input  logic [len_width-1:0] len_i,
  output logic [WORD_W-1:0]    dst_cur_o,
  output logic [WORD_W-1:0]    src_nxt_o,
  output logic [WORD_W-1:0]    dst_nxt_o,
  output logic                 last_o
);

  logic [WORD_W-1:0]    src_q, src_d;
  logic [WORD_W-1:0]    dst_q, dst_d;
  logic [len_width-1:0] rem_q, rem_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      rem_d = len_i;
    end else if (adv_i) begin
      src_d = src_q + WORD_W'(1);
      dst_d = dst_q + WORD_W'(1);
      rem_d = rem_q - len_width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign dst_cur_o = dst_q;
  assign src_nxt_o = src_q + WORD_W'(1);
  assign dst_nxt_o = dst_q + WORD_W'(1);
  // The word being written now is the final one.
  assign last_o    = (rem_q == len_width'(1));

endmodule

// File: rtl/bram32_copier.sv
// Word copier / pattern filler driving a single-port BRAM with registered reads.
// All bus outputs are registers loaded with the bus phase of the next state.
module bram32_copier
  import bram32_copier_pkg::*;
#(
  parameter int len_width = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    src,
  input  logic [ADDR_W-1:0]    dst,
  input  logic [len_width-1:0] len,
  input  logic [DATA_W-1:0]    pattern,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    m_a,
  output logic                 m_we,
  output logic [DATA_W-1:0]    m_do,
  input  logic [DATA_W-1:0]    m_di,
  output logic [2:0]           dbg_state
);

  // Command handshake: start is a one-cycle strobe honoured only in IDLE; abort is
  // honoured in every active state except FINISH, which already ends the command.

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   m_a_q, m_a_d;
  logic                m_we_q, m_we_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic                load, adv, fin;
  logic [WORD_W-1:0]   dst_cur, src_nxt, dst_nxt;
  logic                last;
  logic                unused_low_bits;

  assign unused_low_bits = ^{src[1:0], dst[1:0]};

  bram32_agen #(.len_width(len_width)) u_agen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .adv_i     (adv),
    .src_i     (src[ADDR_W-1:2]),
    .dst_i     (dst[ADDR_W-1:2]),
    .len_i     (len),
    .dst_cur_o (dst_cur),
    .src_nxt_o (src_nxt),
    .dst_nxt_o (dst_nxt),
    .last_o    (last)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    m_a_d     = m_a_q;
    m_we_d    = 1'b0;
    data_d    = data_q;
    pattern_d = pattern_q;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          pattern_d = pattern;
          if (len == '0) begin
            fin = 1'b1;
          end else begin
            busy_d = 1'b1;
            unique case (mode)
              MODE_COPY: begin
                state_d = ST_READ;
                m_a_d   = word_addr(src[ADDR_W-1:2]);
              end
              MODE_FILL: begin
                state_d = ST_FILL;
                m_a_d   = word_addr(dst[ADDR_W-1:2]);
                m_we_d  = 1'b1;
                data_d  = pattern;
              end
            endcase
          end
        end
      end
      ST_READ: begin
        if (abort) fin = 1'b1;
        else       state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (abort) begin
          fin = 1'b1;
        end else begin
          state_d = ST_WRITE;
          m_a_d   = word_addr(dst_cur);
          m_we_d  = 1'b1;
          data_d  = m_di;
        end
      end
      // The write on the bus this cycle always lands, so pointers always advance.
      ST_WRITE: begin
        adv = 1'b1;
        if (abort || last) begin
          fin = 1'b1;
        end else begin
          state_d = ST_READ;
          m_a_d   = word_addr(src_nxt);
        end
      end
      ST_FILL: begin
        adv = 1'b1;
        if (abort || last) begin
          fin = 1'b1;
        end else begin
          m_a_d  = word_addr(dst_nxt);
          m_we_d = 1'b1;
          data_d = pattern_q;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      state_d = ST_FINISH;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      m_we_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_a_q     <= '0;
      m_we_q    <= 1'b0;
      data_q    <= '0;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_a_q     <= m_a_d;
      m_we_q    <= m_we_d;
      data_q    <= data_d;
      pattern_q <= pattern_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_a       = m_a_q;
  assign m_we      = m_we_q;
  assign m_do      = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bram32_copier.sv
// Scoreboarded bench for bram32_copier: a word-level reference model predicts every
// BRAM write, and a negedge monitor checks the writes the DUT actually issues.
module tb_bram32_copier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [9:0]  len = '0;
  logic [31:0] pattern = '0;
  logic [31:0] m_di;
  logic        busy, done, m_we;
  logic [15:0] m_a;
  logic [31:0] m_do;
  logic [2:0]  dbg_state;
  logic        preload = 1'b0;

  logic [31:0] bram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [47:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  bram32_copier #(.len_width(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .pattern   (pattern),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .m_a       (m_a),
    .m_we      (m_we),
    .m_do      (m_do),
    .m_di      (m_di),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] word_init(input int i);
    if (i < 4) return 32'(i + 1);
    return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
  endfunction

  // BRAM: synchronous write, registered read (data one cycle after address).
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) bram[i] <= word_init(i);
    end else if (m_we) begin
      bram[m_a[15:2]] <= m_do;
    end
    m_di <= bram[m_a[15:2]];
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst && done) done_cnt++;
    if (rst && m_we) begin
      we_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required=no write", m_a, m_do);
      end else begin
        e = exp_q.pop_front();
        if ({m_a, m_do} !== e) begin
          errors++;
          $display("FAIL bram_write actual addr=%h data=%h required addr=%h data=%h",
                   m_a, m_do, e[47:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_exp(input logic md, input logic [15:0] s, input logic [15:0] d,
                          input int n, input logic [31:0] pat);
    logic [15:0] a;
    logic [13:0] sw;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      a  = {d[15:2], 2'b00} + 16'(4 * i);
      sw = s[15:2] + 14'(i);
      v  = md ? pat : ref_mem[sw];
      exp_q.push_back({a, v});
      ref_mem[a[15:2]] = v;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_cmd(input logic md, input logic [15:0] s, input logic [15:0] d,
                           input logic [9:0] n, input logic [31:0] pat, input bit ab);
    @(negedge clk);
    start = 1'b1; mode = md; src = s; dst = d; len = n; pattern = pat; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    src = 16'($urandom); dst = 16'($urandom); len = 10'($urandom); pattern = $urandom;
  endtask

  task automatic wait_done(input int budget, input bit spur, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      if (done) begin
        n = k;
        break;
      end
      if (spur && k == 2) begin
        start = 1'b1; mode = ~mode; src = 16'($urandom); dst = 16'($urandom);
        len = 10'($urandom_range(1, 5));
      end
      if (spur && k == 3) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no done required=done within %0d cycles", budget);
    end
  endtask

  task automatic run_cmd(input string name, input logic md, input logic [15:0] s,
                         input logic [15:0] d, input logic [9:0] n, input logic [31:0] pat,
                         input bit spur, input bit ab);
    int we0, dn0, got, exp_cyc;
    we0 = we_cnt;
    dn0 = done_cnt;
    push_exp(md, s, d, int'(n), pat);
    start_cmd(md, s, d, n, pat, ab);
    exp_cyc = (n == 0) ? 1 : (md ? int'(n) + 1 : 3 * int'(n) + 1);
    wait_done(3 * int'(n) + 8, spur, got);
    check({name, "_done_cycle"}, 64'(got), 64'(exp_cyc));
    check({name, "_busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
    check({name, "_writes"}, 64'(we_cnt - we0), 64'(n));
    check({name, "_done_pulses"}, 64'(done_cnt - dn0), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we0, dn0;
    logic [15:0] s, d;
    logic [9:0]  n;
    bit spur;

    for (int i = 0; i < 256; i++) ref_mem[i] = word_init(i);
    repeat (2) @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_m_we", 64'(m_we), 64'(0));
    check("rst_m_a", 64'(m_a), 64'(0));
    check("rst_m_do", 64'(m_do), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst = 1'b1;

    // Four-word copy into an empty region, then inspect the RAM itself.
    run_cmd("copy4", 1'b0, 16'h0000, 16'h0100, 10'd4, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) check("copy4_ram", 64'(bram[64 + i]), 64'(i + 1));

    run_cmd("fill3", 1'b1, 16'h0000, 16'h0040, 10'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_cmd("zero_len", 1'b0, 16'h0000, 16'h0500, 10'd0, 32'h0, 1'b0, 1'b0);
    run_cmd("wrap", 1'b1, 16'h0000, 16'hFFFC, 10'd2, 32'h1234_5678, 1'b0, 1'b0);
    check("wrap_ram_lo", 64'(bram[0]), 64'h1234_5678);

    // Abort during the third READ of an eight-word copy.
    we0 = we_cnt;
    dn0 = done_cnt;
    push_exp(1'b0, 16'h0010, 16'h0200, 2, 32'h0);
    start_cmd(1'b0, 16'h0010, 16'h0200, 10'd8, 32'h0, 1'b0);
    repeat (6) @(negedge clk);
    check("abort_in_read", 64'(dbg_state), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done", 64'(done), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    repeat (10) @(negedge clk);
    check("abort_writes", 64'(we_cnt - we0), 64'(2));
    check("abort_done_pulses", 64'(done_cnt - dn0), 64'(1));

    run_cmd("abort_with_start", 1'b1, 16'h0000, 16'h9200, 10'd2, 32'hA5A5_0F0F, 1'b0, 1'b1);

    // A start coinciding with done must be dropped.
    we0 = we_cnt;
    dn0 = done_cnt;
    push_exp(1'b1, 16'h0000, 16'h9000, 1, 32'h0000_0042);
    start_cmd(1'b1, 16'h0000, 16'h9000, 10'd1, 32'h0000_0042, 1'b0);
    @(negedge clk);
    check("start_at_done_done", 64'(done), 64'(1));
    start = 1'b1; mode = 1'b1; dst = 16'h9100; len = 10'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("start_at_done_writes", 64'(we_cnt - we0), 64'(1));
    check("start_at_done_pulses", 64'(done_cnt - dn0), 64'(1));

    // Reset asserted while the second fill word is on the bus.
    push_exp(1'b1, 16'h0000, 16'h8000, 2, 32'hCAFE_F00D);
    start_cmd(1'b1, 16'h0000, 16'h8000, 10'd5, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    check("rst_mid_pre_we", 64'(m_we), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("rst_mid_m_we", 64'(m_we), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_state", 64'(dbg_state), 64'(0));
    dn0 = done_cnt;
    repeat (4) @(negedge clk);
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_no_done", 64'(done_cnt - dn0), 64'(0));
    rst = 1'b1;
    run_cmd("post_rst", 1'b1, 16'h0000, 16'h8100, 10'd2, 32'h0BAD_CAFE, 1'b0, 1'b0);

    // Randomized commands; some also throw an ignored start mid-transfer.
    for (int t = 0; t < 24; t++) begin
      n = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
      s = 16'($urandom_range(0, 243) * 4) | 16'($urandom_range(0, 3));
      d = 16'(16'h4000 + $urandom_range(0, 8000) * 4) | 16'($urandom_range(0, 3));
      spur = (n >= 3) && ($urandom_range(0, 1) == 1);
      run_cmd("rand", 1'($urandom_range(0, 1)), s, d, n, $urandom, spur, 1'b0);
    end

    check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
